// File: rtl/led_scan_ctrl.sv
// ---------------------------------------------------------------------------
// led_scan_ctrl
//
// Scan controller for a multiplexed seven-segment display behind the EMI
// chip-select decode. Asynchronous EMI write strobes are synchronised into
// the CLK domain, and each strobe assertion commits one write to a small
// register bank. A slot-based FSM then time-multiplexes up to four hex
// digits onto a shared segment bus. It provides per-digit blanking, decimal
// points, ghost blanking between digits and 4-bit PWM brightness.
//
// Ports:
//   CLK        in   1     system clock
//   RST_N      in   1     asynchronous active-low reset
//   LED_SEL_N  in   1     decoded active-low region select (async)
//   BWE_N      in   1     EMI write strobe, active-low (async)
//   ADDR       in   2     register select: 0 DIG01, 1 DIG23, 2 MASK, 3 CTRL
//   DATA       in   8     write data
//   SEG_N      out  7     segments a..g, active-low, bit0 = a
//   DP_N       out  1     decimal point, active-low
//   DIG_EN     out  NDIG  digit enables, active-high, one-hot or zero
// ---------------------------------------------------------------------------
module led_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int SCAN_DIV  = 4096,
    parameter int BLANK_CYC = 64
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            LED_SEL_N,
    input  logic            BWE_N,
    input  logic [1:0]      ADDR,
    input  logic [7:0]      DATA,
    output logic [6:0]      SEG_N,
    output logic            DP_N,
    output logic [NDIG-1:0] DIG_EN
);

    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Write path: 2-flop synchroniser plus one extra flop for edge detect so
    // a long strobe produces exactly one commit.
    // -----------------------------------------------------------------------
    logic wr_act;
    logic sync1_q, sync2_q, sync3_q;
    logic wr_commit;

    assign wr_act    = ~LED_SEL_N & ~BWE_N;
    assign wr_commit = sync2_q & ~sync3_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= wr_act;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Register bank. CTRL[6:4] carry no function and are not stored.
    logic [7:0] dig01_q;
    logic [7:0] dig23_q;
    logic [7:0] mask_q;
    logic [3:0] bright_q;
    logic       scan_en_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dig01_q   <= 8'h00;
            dig23_q   <= 8'h00;
            mask_q    <= 8'h00;
            bright_q  <= 4'hF;
            scan_en_q <= 1'b0;
        end else if (wr_commit) begin
            case (ADDR)
                2'd0:    dig01_q <= DATA;
                2'd1:    dig23_q <= DATA;
                2'd2:    mask_q  <= DATA;
                default: begin
                    bright_q  <= DATA[3:0];
                    scan_en_q <= DATA[7];
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Hex to active-high segment pattern, bit0 = a.
    // -----------------------------------------------------------------------
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // -----------------------------------------------------------------------
    // Scan FSM. The slot counter runs 0..SCAN_DIV-1 across one digit slot;
    // the first BLANK_CYC counts are BLANK, the rest are ON.
    // -----------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     idx_q, idx_d;
    logic [3:0]     pwm_q, pwm_d;
    logic [6:0]     seg_q, seg_d;
    logic           dp_q, dp_d;
    logic           blank_q, blank_d;     // per-slot copy of the digit mask
    logic [NDIG-1:0] dig_en_q, dig_en_d;
    logic [15:0]    digits;
    logic           latch;
    logic           lit;

    assign digits = {dig23_q, dig01_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pwm_d   = pwm_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        latch   = 1'b0;

        if (!scan_en_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = 2'd0;
            pwm_d   = 4'd0;
            seg_d   = 7'h7F;
            dp_d    = 1'b1;
            blank_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    latch   = 1'b1;
                end
                S_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BLANK_CYC - 1)) begin
                        state_d = S_ON;
                        pwm_d   = 4'd0;
                    end
                end
                S_ON: begin
                    if (cnt_q == CW'(SCAN_DIV - 1)) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        idx_d   = (idx_q == 2'(NDIG - 1)) ? 2'd0 : idx_q + 2'd1;
                        latch   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        pwm_d = pwm_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Segment, DP and blank state are captured only at slot start, so
        // register writes mid-slot never disturb the digit being shown.
        if (latch) begin
            seg_d   = ~hex7(digits[{idx_d, 2'b00} +: 4]);
            dp_d    = ~mask_q[{1'b1, idx_d}];
            blank_d = mask_q[{1'b0, idx_d}];
        end

        lit = (state_d == S_ON) && !blank_d &&
              ((bright_q == 4'hF) || (pwm_d < bright_q));
    end

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig_en
            assign dig_en_d[gi] = lit && (idx_d == 2'(gi));
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            pwm_q    <= 4'd0;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            blank_q  <= 1'b0;
            dig_en_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pwm_q    <= pwm_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            dig_en_q <= dig_en_d;
        end
    end

    assign SEG_N  = seg_q;
    assign DP_N   = dp_q;
    assign DIG_EN = dig_en_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for led_scan_ctrl with NDIG=4, SCAN_DIV=256, BLANK_CYC=8.
// Outputs are sampled 1 ns after each rising edge; bus inputs change on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_led_scan_ctrl;

    logic       CLK;
    logic       RST_N;
    logic       LED_SEL_N;
    logic       BWE_N;
    logic [1:0] ADDR;
    logic [7:0] DATA;
    logic [6:0] SEG_N;
    logic       DP_N;
    logic [3:0] DIG_EN;

    int checks = 0;
    int errors = 0;

    led_scan_ctrl #(
        .NDIG      (4),
        .SCAN_DIV  (256),
        .BLANK_CYC (8)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .LED_SEL_N (LED_SEL_N),
        .BWE_N     (BWE_N),
        .ADDR      (ADDR),
        .DATA      (DATA),
        .SEG_N     (SEG_N),
        .DP_N      (DP_N),
        .DIG_EN    (DIG_EN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Count consecutive samples where DIG_EN equals val.
    task automatic count_run(input logic [3:0] val, output int n);
        n = 0;
        while (DIG_EN === val && n < 2000) begin
            n++;
            tick();
        end
    endtask

    // Advance until SEG_N differs from its current value (next slot start).
    task automatic wait_seg_change();
        logic [6:0] s;
        int n;
        s = SEG_N;
        n = 0;
        while (SEG_N === s && n < 3000) begin
            n++;
            tick();
        end
    endtask

    // Advance slot by slot until a slot starts showing val (bounded).
    task automatic wait_seg_to(input logic [6:0] val);
        for (int k = 0; k < 6; k++) begin
            wait_seg_change();
            if (SEG_N === val) break;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge CLK);
        ADDR = a;
        DATA = d;
        LED_SEL_N = 1'b0;
        BWE_N = 1'b0;
        repeat (4) @(negedge CLK);
        BWE_N = 1'b1;
        LED_SEL_N = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    // Start a strobe and count rising edges until SEG_N changes.
    task automatic strobe_measure(input logic [1:0] a, input logic [7:0] d, output int n);
        logic [6:0] s;
        @(negedge CLK);
        s = SEG_N;
        ADDR = a;
        DATA = d;
        LED_SEL_N = 1'b0;
        BWE_N = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (SEG_N === s && n < 20);
        @(negedge CLK);
        BWE_N = 1'b1;
        LED_SEL_N = 1'b1;
    endtask

    initial begin
        logic [6:0] exp_seg [4];
        logic       exp_dp  [4];
        logic [3:0] cur;
        logic [6:0] prev_seg;
        int n;
        int k;
        int on_cnt [4];
        int multi;

        exp_seg = '{7'h40, 7'h00, 7'h79, 7'h0E};
        exp_dp  = '{1'b0, 1'b1, 1'b1, 1'b1};

        RST_N = 1'b0;
        LED_SEL_N = 1'b1;
        BWE_N = 1'b1;
        ADDR = 2'd0;
        DATA = 8'h00;
        #22;
        check("rst_seg", SEG_N, 7'h7F);
        check("rst_dp", DP_N, 1'b1);
        check("rst_en", DIG_EN, 4'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Strobe shorter than a clock period, between edges: ignored.
        @(negedge CLK);
        #1;
        ADDR = 2'd3; DATA = 8'h8F; LED_SEL_N = 1'b0; BWE_N = 1'b0;
        #2;
        BWE_N = 1'b1; LED_SEL_N = 1'b1;
        repeat (20) tick();
        check("glitch_seg", SEG_N, 7'h7F);
        check("glitch_en", DIG_EN, 4'h0);

        // Main scan pattern.
        bus_write(2'd0, 8'h80);
        bus_write(2'd1, 8'hF1);
        bus_write(2'd2, 8'h10);
        strobe_measure(2'd3, 8'h8F, n);
        check("start_latency", n, 4);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("seg_d%0d", d), SEG_N, exp_seg[d]);
            check($sformatf("dp_d%0d", d), DP_N, exp_dp[d]);
            count_run(4'h0, n);
            check($sformatf("blank_d%0d", d), n, 8);
            cur = 4'(1 << d);
            check($sformatf("en_d%0d", d), DIG_EN, cur);
            count_run(cur, n);
            check($sformatf("on_d%0d", d), n, 248);
        end
        check("wrap_seg", SEG_N, 7'h40);

        // Brightness 4: 4 of every 16 ON cycles.
        bus_write(2'd3, 8'h84);
        wait_seg_change();
        count_run(4'h0, n);
        check("pwm4_blank", n, 8);
        cur = DIG_EN;
        check("pwm4_onehot", $onehot(cur), 1);
        count_run(cur, n);
        check("pwm4_on", n, 4);
        count_run(4'h0, n);
        check("pwm4_off", n, 12);

        // Brightness 0: never lit, segments keep scanning.
        bus_write(2'd3, 8'h80);
        wait_seg_change();
        k = 0;
        for (int i = 0; i < 4; i++) if (exp_seg[i] === SEG_N) k = i;
        n = 0;
        for (int i = 0; i < 256; i++) begin
            if (DIG_EN !== 4'h0) n++;
            tick();
        end
        check("pwm0_lit", n, 0);
        check("pwm0_scan", SEG_N, exp_seg[(k + 1) % 4]);

        // Mask digits 0 and 2; frame timing unchanged.
        bus_write(2'd2, 8'h05);
        bus_write(2'd3, 8'h8F);
        wait_seg_to(7'h40);
        for (int b = 0; b < 4; b++) on_cnt[b] = 0;
        multi = 0;
        prev_seg = SEG_N;
        for (int i = 0; i < 1024; i++) begin
            for (int b = 0; b < 4; b++) if (DIG_EN[b]) on_cnt[b]++;
            if (!$onehot0(DIG_EN)) multi++;
            prev_seg = SEG_N;
            tick();
        end
        check("frame_end_seg", prev_seg, 7'h0E);
        check("frame_start_seg", SEG_N, 7'h40);
        check("mask_on0", on_cnt[0], 0);
        check("mask_on1", on_cnt[1], 248);
        check("mask_on2", on_cnt[2], 0);
        check("mask_on3", on_cnt[3], 248);
        check("multi_hot", multi, 0);

        // Strobe without region select: no write.
        @(negedge CLK);
        ADDR = 2'd3; DATA = 8'h00; LED_SEL_N = 1'b1; BWE_N = 1'b0;
        repeat (6) @(negedge CLK);
        BWE_N = 1'b1;
        repeat (2) tick();
        check("nosel_seg", SEG_N, 7'h40);

        // Disable mid-ON on digit 2, then re-enable.
        bus_write(2'd2, 8'h00);
        wait_seg_to(7'h79);
        repeat (50) tick();
        check("d2_on", DIG_EN, 4'h4);
        strobe_measure(2'd3, 8'h0F, n);
        check("stop_latency", n, 4);
        check("stop_en", DIG_EN, 4'h0);
        check("stop_seg", SEG_N, 7'h7F);
        check("stop_dp", DP_N, 1'b1);
        repeat (5) @(negedge CLK);
        strobe_measure(2'd3, 8'h8F, n);
        check("restart_latency", n, 4);
        check("restart_seg", SEG_N, 7'h40);

        // Long strobe with DATA changed mid-strobe: only first value commits.
        @(negedge CLK);
        ADDR = 2'd0; DATA = 8'h23; LED_SEL_N = 1'b0; BWE_N = 1'b0;
        repeat (10) @(negedge CLK);
        DATA = 8'h45;
        repeat (10) @(negedge CLK);
        BWE_N = 1'b1; LED_SEL_N = 1'b1;
        wait_seg_to(7'h30);
        check("long_d0", SEG_N, 7'h30);
        wait_seg_change();
        check("long_d1", SEG_N, 7'h24);
        repeat (20) tick();
        check("pre_rst_en", DIG_EN, 4'h2);

        // Asynchronous reset mid-scan.
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_seg", SEG_N, 7'h7F);
        check("arst_dp", DP_N, 1'b1);
        check("arst_en", DIG_EN, 4'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (20) tick();
        check("post_rst_idle", SEG_N, 7'h7F);
        strobe_measure(2'd3, 8'h8F, n);
        check("post_rst_latency", n, 4);
        check("post_rst_d0", SEG_N, 7'h40);
        check("post_rst_dp", DP_N, 1'b1);
        count_run(4'h0, n);
        check("post_rst_blank", n, 8);
        check("post_rst_en", DIG_EN, 4'h1);
        count_run(4'h1, n);
        check("post_rst_on", n, 248);
        check("post_rst_d1", SEG_N, 7'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
